// File: rtl/fcs_append.sv
// -----------------------------------------------------------------------------
// fcs_append
//
// Final transmit stage in front of the RMII PHY. Forwards the dibit stream from
// ether_out (preamble + SFD + frame body) with one cycle of latency, zero-pads
// short bodies up to the Ethernet minimum, appends the CRC-32 FCS, then holds
// the line idle for the interframe gap before accepting the next frame.
//
// Parameters
//   PREAMBLE_DIBITS  dibits of preamble + SFD forwarded without CRC coverage
//   MIN_FRAME_BYTES  minimum post-SFD bytes before the FCS (0 disables padding)
//   IFG_DIBITS       idle cycles after the last FCS dibit
//
// Ports
//   clk       transmit clock (50 MHz RMII reference), one dibit per cycle
//   rst       asynchronous reset, active low
//   axiiv     input dibit valid; a frame is one contiguous high run
//   axiid     input dibit, axiid[0] is the earlier bit on the wire
//   axiov     output valid (PHY TX_EN), registered
//   axiod     output dibit (PHY TXD), registered, axiod[0] earlier bit
//   ready     high when a new frame may start on the next cycle
//   drop_err  one-cycle pulse when an input dibit arrives outside an
//             accepted frame while ready is low
// -----------------------------------------------------------------------------
module fcs_append #(
    parameter int unsigned PREAMBLE_DIBITS = 32,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned IFG_DIBITS      = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       axiiv,
    input  logic [1:0] axiid,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       ready,
    output logic       drop_err
);

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;

    localparam int unsigned PRE_W  = $clog2(PREAMBLE_DIBITS + 1);
    localparam int unsigned IFG_W  = $clog2(IFG_DIBITS + 1);
    localparam int unsigned BODY_W = 16;

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PREAMBLE_DIBITS - 1);
    localparam logic [IFG_W-1:0]  IFG_LAST  = IFG_W'(IFG_DIBITS - 1);
    localparam logic [BODY_W-1:0] PAD_LIMIT = BODY_W'(4 * MIN_FRAME_BYTES);
    localparam bit                PRE_SKIP  = (PREAMBLE_DIBITS <= 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    state_t             state;
    logic [PRE_W-1:0]   pre_cnt;
    logic [BODY_W-1:0]  body_cnt;
    logic [31:0]        crc;
    logic [29:0]        fcs_sr;
    logic [3:0]         fcs_idx;
    logic [IFG_W-1:0]   ifg_cnt;
    logic               discard;

    logic [31:0]        fcs_val;
    logic [BODY_W:0]    pad_diff;
    logic               need_pad;
    logic               late;

    // Reflected CRC-32, two bits per step, axiid[0] first.
    function automatic logic [31:0] crc_step2(input logic [31:0] c,
                                              input logic [1:0]  d);
        logic [31:0] r;
        r = c;
        for (int unsigned i = 0; i < 2; i++) begin
            if (r[0] ^ d[i])
                r = (r >> 1) ^ CRC_POLY;
            else
                r = r >> 1;
        end
        return r;
    endfunction

    assign fcs_val = ~crc;

    // Borrow-based compare keeps this free of constant-compare corner cases
    // when padding is disabled (PAD_LIMIT == 0).
    assign pad_diff = {1'b0, PAD_LIMIT} - {1'b0, body_cnt};
    assign need_pad = ~pad_diff[BODY_W] & (|pad_diff[BODY_W-1:0]);

    // States in which any input dibit is foreign and must be dropped.
    assign late = (state == ST_PAD) || (state == ST_FCS) || (state == ST_IFG);

    // Held low while a dropped frame is still streaming in, so its tail is not
    // mistaken for a new frame start.
    assign ready = rst & (state == ST_IDLE) & ~discard;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            axiov    <= 1'b0;
            axiod    <= '0;
            drop_err <= 1'b0;
            discard  <= 1'b0;
            pre_cnt  <= '0;
            body_cnt <= '0;
            crc      <= '1;
            fcs_sr   <= '0;
            fcs_idx  <= '0;
            ifg_cnt  <= '0;
        end else begin
            drop_err <= axiiv & late;
            // A run that starts while busy is swallowed until axiiv drops.
            discard  <= axiiv & (discard | late);

            case (state)
                ST_IDLE: begin
                    axiov <= 1'b0;
                    axiod <= '0;
                    if (axiiv && !discard) begin
                        axiov    <= 1'b1;
                        axiod    <= axiid;
                        pre_cnt  <= PRE_W'(1);
                        crc      <= '1;
                        body_cnt <= '0;
                        state    <= PRE_SKIP ? ST_DATA : ST_PRE;
                    end
                end

                ST_PRE: begin
                    if (axiiv) begin
                        axiov   <= 1'b1;
                        axiod   <= axiid;
                        pre_cnt <= pre_cnt + PRE_W'(1);
                        if (pre_cnt == PRE_LAST) begin
                            crc      <= '1;
                            body_cnt <= '0;
                            state    <= ST_DATA;
                        end
                    end else begin
                        // Aborted inside the preamble: no FCS, straight to gap.
                        axiov   <= 1'b0;
                        axiod   <= '0;
                        ifg_cnt <= '0;
                        state   <= ST_IFG;
                    end
                end

                ST_DATA: begin
                    if (axiiv) begin
                        axiov <= 1'b1;
                        axiod <= axiid;
                        crc   <= crc_step2(crc, axiid);
                        if (body_cnt != '1)
                            body_cnt <= body_cnt + BODY_W'(1);
                    end else if (need_pad) begin
                        // First pad dibit goes out in the cycle right after the
                        // last body dibit, keeping axiov continuous.
                        axiov    <= 1'b1;
                        axiod    <= 2'b00;
                        crc      <= crc_step2(crc, 2'b00);
                        body_cnt <= body_cnt + BODY_W'(1);
                        state    <= ST_PAD;
                    end else begin
                        axiov   <= 1'b1;
                        axiod   <= fcs_val[1:0];
                        fcs_sr  <= fcs_val[31:2];
                        fcs_idx <= '0;
                        state   <= ST_FCS;
                    end
                end

                ST_PAD: begin
                    axiov <= 1'b1;
                    if (need_pad) begin
                        axiod    <= 2'b00;
                        crc      <= crc_step2(crc, 2'b00);
                        body_cnt <= body_cnt + BODY_W'(1);
                    end else begin
                        axiod   <= fcs_val[1:0];
                        fcs_sr  <= fcs_val[31:2];
                        fcs_idx <= '0;
                        state   <= ST_FCS;
                    end
                end

                ST_FCS: begin
                    // fcs_idx is the index of the dibit currently on the wire.
                    if (fcs_idx == 4'd15) begin
                        axiov   <= 1'b0;
                        axiod   <= '0;
                        ifg_cnt <= '0;
                        state   <= ST_IFG;
                    end else begin
                        axiov   <= 1'b1;
                        axiod   <= fcs_sr[1:0];
                        fcs_sr  <= {2'b00, fcs_sr[29:2]};
                        fcs_idx <= fcs_idx + 4'd1;
                    end
                end

                ST_IFG: begin
                    axiov <= 1'b0;
                    axiod <= '0;
                    if (ifg_cnt == IFG_LAST)
                        state <= ST_IDLE;
                    else
                        ifg_cnt <= ifg_cnt + IFG_W'(1);
                end

                default: begin
                    axiov <= 1'b0;
                    axiod <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
